// File: rtl/rom_upload_ctrl.sv
// Upload read-back path: serves data_io byte reads from the SDRAM image through
// port1 (toggle req/ack) and keeps the last fetched word as a one-entry cache.
module rom_upload_ctrl #(
  parameter int                ADDR_W  = 25,
  parameter logic [ADDR_W-1:0] BASE    = 25'h0,
  parameter logic [ADDR_W-1:0] LEN     = 25'h10000,
  parameter logic [7:0]        TIMEOUT = 8'd255
) (
  input  logic              clk_sys,
  input  logic              RESETn,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              port1_req,
  input  logic              port1_ack,
  output logic [22:0]       port1_a,
  output logic [1:0]        port1_ds,
  output logic              port1_we,
  input  logic [15:0]       port1_q,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic              rd_d, upload_d;
  logic              rd_edge, upload_rise, upload_fall;
  logic [ADDR_W-1:0] new_off;

  logic [7:0]        din_nxt;
  logic              req_nxt, busy_nxt, err_nxt, err_set;
  logic [22:0]       a_nxt;

  logic              cache_valid, valid_nxt;
  logic [ADDR_W-2:0] cache_tag, tag_nxt;
  logic [15:0]       cache_word, word_nxt;

  logic              pend_valid, pend_valid_nxt, consumed;
  logic [ADDR_W-1:0] pend_off, pend_off_nxt;
  logic              pend_in_win, pend_hit;

  logic [ADDR_W-1:0] cur_off, cur_off_nxt;
  logic [7:0]        tmo_cnt, tmo_nxt;
  logic              discard, discard_nxt, drop_data;

  assign port1_ds = 2'b11;
  assign port1_we = 1'b0;

  assign rd_edge     = ioctl_rd & ~rd_d & ioctl_upload & (state != S_SYNC);
  assign upload_rise = ioctl_upload & ~upload_d;
  assign upload_fall = ~ioctl_upload & upload_d;
  assign new_off     = ioctl_addr - BASE;
  assign pend_in_win = pend_off < LEN;
  assign pend_hit    = cache_valid && (cache_tag == pend_off[ADDR_W-1:1]);
  assign drop_data   = discard | upload_fall;

  // Every request, including one arriving while idle, passes through the
  // pending slot; IDLE serves it on the following cycle.
  always_comb begin
    state_nxt      = state;
    din_nxt        = ioctl_din;
    req_nxt        = port1_req;
    a_nxt          = port1_a;
    busy_nxt       = busy;
    valid_nxt      = cache_valid;
    tag_nxt        = cache_tag;
    word_nxt       = cache_word;
    pend_valid_nxt = pend_valid;
    pend_off_nxt   = pend_off;
    cur_off_nxt    = cur_off;
    tmo_nxt        = tmo_cnt;
    discard_nxt    = discard;
    err_set        = 1'b0;
    consumed       = 1'b0;

    case (state)
      S_SYNC: begin
        req_nxt   = port1_ack;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (pend_valid && ioctl_upload) begin
          consumed = 1'b1;
          if (!pend_in_win) begin
            din_nxt = 8'hFF;
          end else if (pend_hit) begin
            din_nxt = pend_off[0] ? cache_word[15:8] : cache_word[7:0];
          end else begin
            a_nxt       = pend_off[23:1];
            req_nxt     = ~port1_req;
            busy_nxt    = 1'b1;
            cur_off_nxt = pend_off;
            tmo_nxt     = '0;
            discard_nxt = 1'b0;
            state_nxt   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (port1_ack == port1_req) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
          if (!drop_data) begin
            word_nxt  = port1_q;
            tag_nxt   = cur_off[ADDR_W-1:1];
            valid_nxt = 1'b1;
            din_nxt   = cur_off[0] ? port1_q[15:8] : port1_q[7:0];
          end
        end else if (tmo_cnt == TIMEOUT) begin
          err_set   = 1'b1;
          valid_nxt = 1'b0;
          req_nxt   = port1_ack;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
          if (!drop_data) din_nxt = 8'hFF;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end
      default: state_nxt = S_SYNC;
    endcase

    if (consumed) pend_valid_nxt = 1'b0;
    if (rd_edge) begin
      if (pend_valid && !consumed) err_set = 1'b1;
      pend_valid_nxt = 1'b1;
      pend_off_nxt   = new_off;
    end

    // Ending an upload forgets everything; an in-flight fetch still completes
    // on the bus but its data must not reach the cache or data_io.
    if (upload_fall) begin
      valid_nxt      = 1'b0;
      pend_valid_nxt = 1'b0;
      if (state == S_WAIT) discard_nxt = 1'b1;
    end

    err_nxt = err_set | (err & ~upload_rise);
  end

  always_ff @(posedge clk_sys or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_SYNC;
      rd_d        <= 1'b0;
      upload_d    <= 1'b0;
      ioctl_din   <= 8'hFF;
      port1_req   <= 1'b0;
      port1_a     <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_word  <= '0;
      pend_valid  <= 1'b0;
      pend_off    <= '0;
      cur_off     <= '0;
      tmo_cnt     <= '0;
      discard     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_d        <= ioctl_rd;
      upload_d    <= ioctl_upload;
      ioctl_din   <= din_nxt;
      port1_req   <= req_nxt;
      port1_a     <= a_nxt;
      busy        <= busy_nxt;
      err         <= err_nxt;
      cache_valid <= valid_nxt;
      cache_tag   <= tag_nxt;
      cache_word  <= word_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_off    <= pend_off_nxt;
      cur_off     <= cur_off_nxt;
      tmo_cnt     <= tmo_nxt;
      discard     <= discard_nxt;
    end
  end

endmodule
